uart_rx16: RTL and testbench

- 8N1 UART receiver that consumes the 16x-oversampled baud tick produced by the design's clock divider (50 MHz / 326 ≈ 16 × 9600).
- Synchronises the serial input, finds the start-bit edge, samples each bit at mid-period, and presents a parallel byte with a one-cycle valid strobe.
- Sits between the board RX pin and the consuming logic (command decoder or display).

---
 rtl/uart_pkg.sv | 17 +
 rtl/uart_sync.sv | 21 ++
 rtl/uart_rx16.sv | 164 ++++++++++++++++
 tb/tb_uart_rx16.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding and oversampling constants,
// used by both the receiver and the transmitter.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } uart_state_t;

  localparam int          OVERSAMPLE  = 16;
  localparam logic [3:0]  MID_SAMPLE  = 4'd7;
  localparam logic [3:0]  LAST_SAMPLE = 4'd15;

endpackage

// File: rtl/uart_sync.sv
// Flop-chain synchroniser for asynchronous level inputs; resets to 1 so an
// idle-high line does not look like an edge coming out of reset.
module uart_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] chain;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) chain <= '1;
    else        chain <= {chain[STAGES-2:0], d};
  end

  assign q = chain[STAGES-1];

endmodule

// File: rtl/uart_rx16.sv
// 16x-oversampled UART receiver, 8N1 by default; define UART_RX_PARITY_EN
// to receive 8E1 frames and expose parity_err.
module uart_rx16
  import uart_pkg::*;
#(
  parameter int DATA_BITS   = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 clkin,
  input  logic                 rst_n,
  input  logic                 tick16,
  input  logic                 rxd,
  output logic [DATA_BITS-1:0] data,
  output logic                 valid,
  output logic                 frame_err,
`ifdef UART_RX_PARITY_EN
  output logic                 parity_err,
`endif
  output logic                 busy
);

  localparam logic [3:0] BCNT_LAST = 4'(DATA_BITS - 1);

  uart_state_t          state, state_nxt;
  logic [3:0]           scnt, scnt_nxt;
  logic [3:0]           bcnt, bcnt_nxt;
  logic                 armed, armed_nxt;
  logic [DATA_BITS-1:0] shift, shift_nxt;
  logic [DATA_BITS-1:0] data_nxt;
  logic                 valid_nxt, ferr_nxt;
  logic                 rxd_s;
`ifdef UART_RX_PARITY_EN
  logic                 par, par_nxt;
  logic                 perr_nxt;
`endif

  uart_sync #(.STAGES(SYNC_STAGES)) u_sync (
    .clk   (clkin),
    .rst_n (rst_n),
    .d     (rxd),
    .q     (rxd_s)
  );

  assign busy = (state != IDLE);

  always_comb begin
    state_nxt = state;
    scnt_nxt  = scnt;
    bcnt_nxt  = bcnt;
    armed_nxt = armed;
    shift_nxt = shift;
    data_nxt  = data;
    valid_nxt = 1'b0;
    ferr_nxt  = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_nxt   = par;
    perr_nxt  = 1'b0;
`endif
    if (tick16) begin
      case (state)
        IDLE: begin
          scnt_nxt = 4'd0;
          // Only a high-to-low transition starts a frame, so a held break is ignored.
          if (rxd_s) begin
            armed_nxt = 1'b1;
          end else if (armed) begin
            armed_nxt = 1'b0;
            state_nxt = START;
          end
        end
        START: begin
          scnt_nxt = scnt + 4'd1;
          if (scnt == MID_SAMPLE) begin
            scnt_nxt  = 4'd0;
            bcnt_nxt  = 4'd0;
            state_nxt = rxd_s ? IDLE : DATA;
          end
        end
        DATA: begin
          scnt_nxt = scnt + 4'd1;
          if (scnt == LAST_SAMPLE) begin
            shift_nxt = {rxd_s, shift[DATA_BITS-1:1]};
            bcnt_nxt  = bcnt + 4'd1;
            if (bcnt == BCNT_LAST) begin
              bcnt_nxt  = 4'd0;
`ifdef UART_RX_PARITY_EN
              state_nxt = PARITY;
`else
              state_nxt = STOP;
`endif
            end
          end
        end
`ifdef UART_RX_PARITY_EN
        PARITY: begin
          scnt_nxt = scnt + 4'd1;
          if (scnt == LAST_SAMPLE) begin
            par_nxt   = rxd_s;
            state_nxt = STOP;
          end
        end
`endif
        STOP: begin
          scnt_nxt = scnt + 4'd1;
          if (scnt == LAST_SAMPLE) begin
            scnt_nxt  = 4'd0;
            state_nxt = IDLE;
            armed_nxt = rxd_s;
            if (!rxd_s) begin
              ferr_nxt = 1'b1;
`ifdef UART_RX_PARITY_EN
            end else if (^{shift, par}) begin
              perr_nxt = 1'b1;
`endif
            end else begin
              valid_nxt = 1'b1;
              data_nxt  = shift;
            end
          end
        end
        default: begin
          state_nxt = IDLE;
          scnt_nxt  = 4'd0;
          bcnt_nxt  = 4'd0;
        end
      endcase
    end
  end

  always_ff @(posedge clkin or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      scnt      <= 4'd0;
      bcnt      <= 4'd0;
      armed     <= 1'b0;
      data      <= '0;
      valid     <= 1'b0;
      frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err <= 1'b0;
`endif
    end else begin
      state     <= state_nxt;
      scnt      <= scnt_nxt;
      bcnt      <= bcnt_nxt;
      armed     <= armed_nxt;
      data      <= data_nxt;
      valid     <= valid_nxt;
      frame_err <= ferr_nxt;
`ifdef UART_RX_PARITY_EN
      parity_err <= perr_nxt;
`endif
    end
  end

  // Shift register and captured parity bit are pure datapath; no reset needed.
  always_ff @(posedge clkin) begin
    shift <= shift_nxt;
`ifdef UART_RX_PARITY_EN
    par   <= par_nxt;
`endif
  end

endmodule

// File: tb/tb_uart_rx16.sv
// Directed bench for uart_rx16: 16x tick every 4 clkin cycles, so one bit
// period is 64 clkin cycles.
module tb_uart_rx16;

  localparam int BIT_CYC = 64;

  logic       clkin  = 1'b0;
  logic       rst_n  = 1'b0;
  logic       tick16 = 1'b0;
  logic       rxd    = 1'b1;
  logic [1:0] tdiv   = 2'd0;
  logic [7:0] data;
  logic       valid, frame_err, busy;
`ifdef UART_RX_PARITY_EN
  logic       parity_err;
`endif

  int checks   = 0;
  int failures = 0;

  int vcount = 0, fcount = 0, pcount = 0, both = 0, busy_ticks = 0, busy_at_valid = 0;
  logic [7:0] last_data = 8'h00, prev_data = 8'h00;
  int v0, f0, b0, p0;

  uart_rx16 #(.DATA_BITS(8), .SYNC_STAGES(2)) dut (
    .clkin      (clkin),
    .rst_n      (rst_n),
    .tick16     (tick16),
    .rxd        (rxd),
    .data       (data),
    .valid      (valid),
    .frame_err  (frame_err),
`ifdef UART_RX_PARITY_EN
    .parity_err (parity_err),
`endif
    .busy       (busy)
  );

  always #10 clkin = ~clkin;

  always @(posedge clkin) begin
    tdiv   <= tdiv + 2'd1;
    tick16 <= (tdiv == 2'd3);
  end

  always @(negedge clkin) begin
    if (rst_n) begin
      if (valid) begin
        vcount    <= vcount + 1;
        prev_data <= last_data;
        last_data <= data;
        if (busy) busy_at_valid <= busy_at_valid + 1;
      end
      if (frame_err) fcount <= fcount + 1;
      if (valid && frame_err) both <= both + 1;
`ifdef UART_RX_PARITY_EN
      if (parity_err) pcount <= pcount + 1;
      if (valid && parity_err) both <= both + 1;
`endif
      if (tick16 && busy) busy_ticks <= busy_ticks + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clkin);
  endtask

  task automatic send_bit(input logic b);
    rxd = b;
    wait_cyc(BIT_CYC);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_bit);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
`ifdef UART_RX_PARITY_EN
    send_bit(^b);
`endif
    send_bit(stop_bit);
    rxd = 1'b1;
  endtask

  initial begin
    // Reset state
    wait_cyc(3);
    check("rst_data",      32'(data),      32'h0);
    check("rst_valid",     32'(valid),     32'h0);
    check("rst_frame_err", 32'(frame_err), 32'h0);
    check("rst_busy",      32'(busy),      32'h0);
    rst_n = 1'b1;
    wait_cyc(2 * BIT_CYC);

    // Good frame 0xA5
    v0 = vcount; f0 = fcount;
    send_frame(8'hA5, 1'b1);
    wait_cyc(BIT_CYC);
    check("a5_valid_count", 32'(vcount - v0),  32'd1);
    check("a5_data",        32'(data),         32'hA5);
    check("a5_mon_data",    32'(last_data),    32'hA5);
    check("a5_ferr_count",  32'(fcount - f0),  32'd0);
    check("a5_busy_end",    32'(busy),         32'h0);
    check("a5_busy_at_vld", 32'(busy_at_valid), 32'd0);

    // Start glitch of 4 ticks: false start after 8 ticks in START
    v0 = vcount; f0 = fcount; b0 = busy_ticks;
    rxd = 1'b0;
    wait_cyc(16);
    rxd = 1'b1;
    wait_cyc(200);
    check("glitch_valid", 32'(vcount - v0),     32'd0);
    check("glitch_ferr",  32'(fcount - f0),     32'd0);
    check("glitch_busy",  32'(busy_ticks - b0), 32'd8);
    check("glitch_idle",  32'(busy),            32'h0);

    // 0x3C with low stop bit, then line held low 64 ticks
    v0 = vcount; f0 = fcount;
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(8'h3C >> i);
`ifdef UART_RX_PARITY_EN
    send_bit(1'b0);
`endif
    send_bit(1'b0);
    b0 = busy_ticks;
    check("ferr_count", 32'(fcount - f0), 32'd1);
    check("ferr_valid", 32'(vcount - v0), 32'd0);
    check("ferr_data",  32'(data),        32'hA5);
    wait_cyc(64 * 4);
    check("break_busy",  32'(busy_ticks - b0), 32'd0);
    check("break_ferr",  32'(fcount - f0),     32'd1);
    check("break_valid", 32'(vcount - v0),     32'd0);
    rxd = 1'b1;
    wait_cyc(2 * BIT_CYC);

    // Back-to-back 0x00 then 0xFF
    v0 = vcount;
    send_frame(8'h00, 1'b1);
    send_frame(8'hFF, 1'b1);
    wait_cyc(BIT_CYC);
    check("b2b_count",  32'(vcount - v0), 32'd2);
    check("b2b_first",  32'(prev_data),   32'h00);
    check("b2b_second", 32'(last_data),   32'hFF);
    check("b2b_data",   32'(data),        32'hFF);

    // Reset during bit 3 of 0x55, then 0x81
    v0 = vcount;
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    rxd = 1'b0;
    wait_cyc(32);
    rst_n = 1'b0;
    wait_cyc(2);
    check("midrst_busy",  32'(busy),  32'h0);
    check("midrst_valid", 32'(valid), 32'h0);
    check("midrst_data",  32'(data),  32'h0);
    wait_cyc(30);
    rst_n = 1'b1;
    rxd = 1'b1;
    wait_cyc(2 * BIT_CYC);
    check("postrst_idle", 32'(busy), 32'h0);
    send_frame(8'h81, 1'b1);
    wait_cyc(BIT_CYC);
    check("postrst_count", 32'(vcount - v0), 32'd1);
    check("postrst_data",  32'(data),        32'h81);

`ifdef UART_RX_PARITY_EN
    // Even parity: 0x07 has three ones, so a parity bit of 1 is good
    v0 = vcount; p0 = pcount;
    send_frame(8'h07, 1'b1);
    wait_cyc(BIT_CYC);
    check("par_ok_valid", 32'(vcount - v0), 32'd1);
    check("par_ok_data",  32'(data),        32'h07);
    check("par_ok_perr",  32'(pcount - p0), 32'd0);
    v0 = vcount; p0 = pcount;
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(8'h07 >> i);
    send_bit(1'b0);
    send_bit(1'b1);
    wait_cyc(BIT_CYC);
    check("par_bad_perr",  32'(pcount - p0), 32'd1);
    check("par_bad_valid", 32'(vcount - v0), 32'd0);
    check("par_bad_data",  32'(data),        32'h07);
`endif

    check("never_both", 32'(both), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
